// File: rtl/carfield_wdt_pkg.sv
// Shared definitions for the Carfield APB watchdog.
// Register offsets, bit positions, FSM states and the default kick key.
package carfield_wdt_pkg;

    localparam logic [31:0] WDT_KICK_KEY = 32'h5A5A_C0DE;

    localparam int unsigned OFF_CTRL   = 'h00;
    localparam int unsigned OFF_LOAD   = 'h04;
    localparam int unsigned OFF_WARN   = 'h08;
    localparam int unsigned OFF_COUNT  = 'h0C;
    localparam int unsigned OFF_KICK   = 'h10;
    localparam int unsigned OFF_STATUS = 'h14;
    localparam int unsigned OFF_PRESC  = 'h18;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_LOCK   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned ST_WARN    = 0;
    localparam int unsigned ST_EXPIRED = 1;

    localparam int unsigned PRESC_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } wdt_state_e;

endpackage

// File: rtl/carfield_wdt_prescaler.sv
// Tick generator: one tick every presc_i+1 enabled cycles.
// Clearing restarts the period from presc_i.
module carfield_wdt_prescaler
    import carfield_wdt_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    assign tick_o = en_i & (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = presc_i;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? presc_i : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/carfield_apb_watchdog.sv
// APB3 system watchdog: down-counter with kick key, pre-warning irq, reset request.
// Optional prescaler register at 0x18 enabled by CARFIELD_WDT_PRESCALER_EN.
module carfield_apb_watchdog
    import carfield_wdt_pkg::*;
#(
    parameter int unsigned          AddrWidth = 12,
    parameter int unsigned          DataWidth = 32,
    parameter logic [DataWidth-1:0] KickKey   = WDT_KICK_KEY,
    parameter logic [DataWidth-1:0] ResetLoad = 32'hFFFF_FFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [DataWidth-1:0] pwdata_i,
    output logic [DataWidth-1:0] prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic                 irq_o,
    output logic                 rst_req_o
);

    if (DataWidth != 32) begin : g_dw_check
        $error("carfield_apb_watchdog: DataWidth must be 32");
    end

    localparam int unsigned AW = AddrWidth - 2;
`ifdef CARFIELD_WDT_PRESCALER_EN
    localparam int unsigned LastIdx = OFF_PRESC >> 2;
`else
    localparam int unsigned LastIdx = OFF_STATUS >> 2;
`endif

    wdt_state_e           state_q, state_d;
    logic                 en_q, lock_q, irq_en_q;
    logic [DataWidth-1:0] load_q, warn_thr_q, count_q, count_d;
    logic [DataWidth-1:0] prdata_q, rdata;
    logic                 st_warn_q, st_warn_d, st_exp_q, st_exp_d;
    logic                 warn_set, exp_set, run_entry;
    logic                 tick, kick, en_d, w1c_exp;

    logic [AW-1:0] widx;
    logic          setup, access, mapped, err, wr, lock_err;
    logic          sel_ctrl, sel_load, sel_warn, sel_count;
    logic          sel_kick, sel_status, sel_presc;
    logic          unused_addr;

    assign widx        = paddr_i[AddrWidth-1:2];
    assign unused_addr = ^paddr_i[1:0];
    assign setup       = psel_i & ~penable_i;
    assign access      = psel_i & penable_i;

    assign sel_ctrl   = widx == AW'(OFF_CTRL >> 2);
    assign sel_load   = widx == AW'(OFF_LOAD >> 2);
    assign sel_warn   = widx == AW'(OFF_WARN >> 2);
    assign sel_count  = widx == AW'(OFF_COUNT >> 2);
    assign sel_kick   = widx == AW'(OFF_KICK >> 2);
    assign sel_status = widx == AW'(OFF_STATUS >> 2);
    assign mapped     = widx <= AW'(LastIdx);

    assign lock_err  = lock_q & (sel_ctrl | sel_load | sel_warn | sel_presc);
    assign err       = ~mapped | (pwrite_i & (sel_count | lock_err));
    assign wr        = access & pwrite_i & ~err;
    assign pready_o  = access;
    assign pslverr_o = access & err;
    assign prdata_o  = prdata_q;
    assign irq_o     = st_warn_q & irq_en_q;
    assign rst_req_o = st_exp_q;

    assign en_d    = (wr & sel_ctrl) ? pwdata_i[CTRL_EN] : en_q;
    assign w1c_exp = wr & sel_status & pwdata_i[ST_EXPIRED];
    assign kick    = wr & sel_kick & (pwdata_i == KickKey) & (state_q == RUN);

`ifdef CARFIELD_WDT_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q;

    assign sel_presc = widx == AW'(OFF_PRESC >> 2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else if (wr & sel_presc) begin
            presc_q <= pwdata_i[PRESC_W-1:0];
        end
    end

    carfield_wdt_prescaler u_presc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (run_entry | kick),
        .en_i   (state_q == RUN),
        .presc_i(presc_q),
        .tick_o (tick)
    );
`else
    assign sel_presc = 1'b0;
    assign tick      = 1'b1;
`endif

    always_comb begin
        rdata = '0;
        if (sel_ctrl)   rdata[2:0] = {irq_en_q, lock_q, en_q};
        if (sel_load)   rdata = load_q;
        if (sel_warn)   rdata = warn_thr_q;
        if (sel_count)  rdata = count_q;
        if (sel_status) rdata[1:0] = {st_exp_q, st_warn_q};
`ifdef CARFIELD_WDT_PRESCALER_EN
        if (sel_presc)  rdata[PRESC_W-1:0] = presc_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        warn_set  = 1'b0;
        exp_set   = 1'b0;
        run_entry = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_d) begin
                    state_d   = RUN;
                    run_entry = 1'b1;
                end
            end
            RUN: begin
                if (!en_d) begin
                    state_d = IDLE;
                end else if (kick) begin
                    count_d = load_q;
                end else if (tick) begin
                    // Reaching zero is the expiry point; zero itself never wraps.
                    count_d = (count_q == '0) ? '0 : count_q - 1'b1;
                    if (count_q <= 1) begin
                        state_d = EXPIRED;
                        exp_set = 1'b1;
                    end
                    if (count_q != '0 && (count_q - 1'b1) == warn_thr_q) begin
                        warn_set = 1'b1;
                    end
                end
            end
            EXPIRED: begin
                if (w1c_exp) begin
                    state_d   = en_q ? RUN : IDLE;
                    run_entry = en_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (run_entry) begin
            count_d = load_q;
            if (warn_thr_q >= load_q) warn_set = 1'b1;
        end
        st_warn_d = (st_warn_q & ~(wr & sel_status & pwdata_i[ST_WARN])) | warn_set;
        st_exp_d  = (st_exp_q & ~w1c_exp) | exp_set;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            count_q    <= ResetLoad;
            load_q     <= ResetLoad;
            warn_thr_q <= '0;
            en_q       <= 1'b0;
            lock_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            st_warn_q  <= 1'b0;
            st_exp_q   <= 1'b0;
            prdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            st_warn_q <= st_warn_d;
            st_exp_q  <= st_exp_d;
            if (setup) prdata_q <= pwrite_i ? '0 : rdata;
            if (wr & sel_ctrl) begin
                en_q     <= pwdata_i[CTRL_EN];
                lock_q   <= lock_q | pwdata_i[CTRL_LOCK];
                irq_en_q <= pwdata_i[CTRL_IRQ_EN];
            end
            if (wr & sel_load) load_q <= pwdata_i;
            if (wr & sel_warn) warn_thr_q <= pwdata_i;
        end
    end

endmodule

// File: tb/tb_carfield_apb_watchdog.sv
// Directed self-checking bench for carfield_apb_watchdog (default build).
// Each task drives one scenario and compares against hand-computed values.
module tb_carfield_apb_watchdog;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr, irq, rst_req;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] KEY = 32'h5A5A_C0DE;

    always #5 clk = ~clk;

    carfield_apb_watchdog dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .psel_i   (psel),
        .penable_i(penable),
        .pwrite_i (pwrite),
        .paddr_i  (paddr),
        .pwdata_i (pwdata),
        .prdata_o (prdata),
        .pready_o (pready),
        .pslverr_o(pslverr),
        .irq_o    (irq),
        .rst_req_o(rst_req)
    );

    // Update edge is the third rising edge after the call.
    task automatic apb(input logic w, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err, output logic rdy);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        rd = prdata; err = pslverr; rdy = pready;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset;
        logic [11:0] addrs [5] = '{12'h00, 12'h04, 12'h08, 12'h0C, 12'h14};
        logic [31:0] exps  [5] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] rd;
        logic e, r;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({irq, rst_req, pslverr, pready} !== 4'b0 || prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got irq=%b rst=%b err=%b rdy=%b rd=%h want 0",
                     irq, rst_req, pslverr, pready, prdata);
        end
        for (int i = 0; i < 5; i++) begin
            apb(1'b0, addrs[i], 32'h0, rd, e, r);
            checks++;
            if (rd !== exps[i] || e !== 1'b0 || r !== 1'b1) begin
                errors++;
                $display("FAIL reset_read[%h]: got %h err=%b rdy=%b want %h err=0 rdy=1",
                         addrs[i], rd, e, r, exps[i]);
            end
        end
    endtask

    task automatic test_expiry_warn;
        logic [31:0] rd;
        logic e, r;
        int t_irq = -1;
        int t_rst = -1;
        apb(1'b1, 12'h04, 32'd20, rd, e, r);
        apb(1'b1, 12'h08, 32'd5, rd, e, r);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL write_prdata: got %h err=%b want 0 err=0", rd, e);
        end
        apb(1'b1, 12'h00, 32'h5, rd, e, r);
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            if (irq && t_irq < 0) t_irq = k;
            if (rst_req && t_rst < 0) t_rst = k;
        end
        checks++;
        if (t_irq != 15) begin
            errors++;
            $display("FAIL irq_time: got %0d want 15", t_irq);
        end
        checks++;
        if (t_rst != 20) begin
            errors++;
            $display("FAIL expiry_time: got %0d want 20", t_rst);
        end
        repeat (5) @(posedge clk);
        apb(1'b0, 12'h0C, 32'h0, rd, e, r);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL count_saturate: got %h want 0", rd);
        end
        apb(1'b0, 12'h14, 32'h0, rd, e, r);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL status_expired: got %h want 3", rd);
        end
        apb(1'b1, 12'h00, 32'h0, rd, e, r);
        checks++;
        if (rst_req !== 1'b1) begin
            errors++;
            $display("FAIL en0_keeps_req: got %b want 1", rst_req);
        end
        apb(1'b1, 12'h14, 32'h3, rd, e, r);
        checks++;
        if (rst_req !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear: got rst=%b irq=%b want 0 0", rst_req, irq);
        end
        apb(1'b0, 12'h14, 32'h0, rd, e, r);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL status_after_w1c: got %h want 0", rd);
        end
    endtask

    task automatic test_kick;
        logic [31:0] rd;
        logic e, r;
        int t_rst = -1;
        apb(1'b1, 12'h04, 32'd10, rd, e, r);
        apb(1'b1, 12'h08, 32'd0, rd, e, r);
        apb(1'b1, 12'h00, 32'h1, rd, e, r);
        repeat (5) @(posedge clk);
        apb(1'b1, 12'h10, KEY, rd, e, r);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL kick_err: got %b want 0", e);
        end
        apb(1'b0, 12'h0C, 32'h0, rd, e, r);
        checks++;
        if (rd !== 32'd9) begin
            errors++;
            $display("FAIL kick_reload: got %0d want 9", rd);
        end
        for (int k = 4; k <= 15; k++) begin
            @(posedge clk); #1;
            if (rst_req && t_rst < 0) t_rst = k;
        end
        checks++;
        if (t_rst != 10) begin
            errors++;
            $display("FAIL kick_expiry_time: got %0d want 10", t_rst);
        end
        apb(1'b1, 12'h00, 32'h0, rd, e, r);
        apb(1'b1, 12'h14, 32'h3, rd, e, r);
    endtask

    task automatic test_bad_kick;
        logic [31:0] rd;
        logic e, r;
        int t_rst = -1;
        apb(1'b1, 12'h00, 32'h1, rd, e, r);
        repeat (5) @(posedge clk);
        apb(1'b1, 12'h10, 32'h0000_1234, rd, e, r);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL bad_kick_err: got %b want 0", e);
        end
        for (int k = 1; k <= 6; k++) begin
            if (rst_req && t_rst < 0) t_rst = k - 1;
            @(posedge clk); #1;
        end
        checks++;
        if (t_rst != 2) begin
            errors++;
            $display("FAIL bad_kick_expiry: got %0d want 2", t_rst);
        end
        apb(1'b1, 12'h00, 32'h0, rd, e, r);
        apb(1'b1, 12'h14, 32'h3, rd, e, r);
    endtask

    task automatic test_kick_at_expiry;
        logic [31:0] rd;
        logic e, r;
        apb(1'b1, 12'h00, 32'h1, rd, e, r);
        repeat (7) @(posedge clk);
        apb(1'b1, 12'h10, KEY, rd, e, r);
        apb(1'b0, 12'h0C, 32'h0, rd, e, r);
        checks++;
        if (rd !== 32'd9 || rst_req !== 1'b0) begin
            errors++;
            $display("FAIL kick_vs_expiry: got count=%0d rst=%b want 9 0", rd, rst_req);
        end
        apb(1'b1, 12'h00, 32'h0, rd, e, r);
    endtask

    task automatic test_unmapped;
        logic [31:0] rd;
        logic e, r;
        apb(1'b0, 12'h20, 32'h0, rd, e, r);
        checks++;
        if (e !== 1'b1 || r !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_20: got err=%b rdy=%b want 1 1", e, r);
        end
`ifndef CARFIELD_WDT_PRESCALER_EN
        apb(1'b1, 12'h18, 32'h3, rd, e, r);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_18: got err=%b want 1", e);
        end
`endif
        apb(1'b1, 12'h0C, 32'h5, rd, e, r);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL write_count: got err=%b want 1", e);
        end
        apb(1'b0, 12'h10, 32'h0, rd, e, r);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL kick_read: got %h err=%b want 0 0", rd, e);
        end
    endtask

    task automatic test_mid_reset;
        logic [31:0] rd;
        logic e, r;
        apb(1'b1, 12'h04, 32'd50, rd, e, r);
        apb(1'b1, 12'h00, 32'h5, rd, e, r);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        apb(1'b0, 12'h00, 32'h0, rd, e, r);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got %h want 0", rd);
        end
        apb(1'b0, 12'h0C, 32'h0, rd, e, r);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mid_reset_count: got %h want ffffffff", rd);
        end
    endtask

    task automatic test_lock;
        logic [31:0] rd;
        logic e, r;
        apb(1'b1, 12'h04, 32'd10, rd, e, r);
        apb(1'b1, 12'h00, 32'h2, rd, e, r);
        apb(1'b1, 12'h04, 32'd7, rd, e, r);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL lock_load_err: got %b want 1", e);
        end
        apb(1'b0, 12'h04, 32'h0, rd, e, r);
        checks++;
        if (rd !== 32'd10 || e !== 1'b0) begin
            errors++;
            $display("FAIL lock_load_value: got %0d err=%b want 10 0", rd, e);
        end
        apb(1'b1, 12'h00, 32'h0, rd, e, r);
        apb(1'b0, 12'h00, 32'h0, rd, e, r);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL lock_ctrl: got %h want 2", rd);
        end
        apb(1'b1, 12'h08, 32'h9, rd, e, r);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL lock_warn_err: got %b want 1", e);
        end
    endtask

    initial begin
        test_reset();
        test_expiry_warn();
        test_kick();
        test_bad_kick();
        test_kick_at_expiry();
        test_unmapped();
        test_mid_reset();
        test_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
